arcade_input_mapper: RTL

Parametrised player-input front end for arcade cores. It sits between `hps_io` (PS/2 key stream, MiSTer joysticks) and the core's active-low input ports. It produces registered, active-high per-player control words. Features: keyboard latching for up to two players, four-way screen-rotation remap, opposite-direction cancel, and a timed coin pulse generator.

---
 rtl/arcade_input_mapper.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/arcade_input_mapper.sv
// Player-input front end: PS/2 key latches and MiSTer joysticks merged into registered active-high control words.
// Optional autofire on joystick bit [8] is built when INPUT_AUTOFIRE_EN is defined.
module arcade_input_mapper #(
    parameter int          PLAYERS         = 2,
    parameter logic [15:0] COIN_PULSE      = 16'd50000,
    parameter bit          COIN_FROM_START = 1'b1,
    parameter int unsigned AF_DIV          = 200000
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic [64:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic [1:0]  rotate,
    output logic [7:0]  p1_ctrl,
    output logic [7:0]  p2_ctrl,
    output logic        key_event
);
    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_WAIT} coin_state_e;

    logic        tog_q, tog_d;
    logic        primed_q, primed_d;
    logic        key_event_q, key_event_d;
    logic [16:0] kl_q, kl_d;
    logic [1:0]  rot_q, rot_d;
    logic [6:0]  ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d;
    logic        evt, pressed, ext;
    logic [8:0]  code;
    logic [7:0]  k1, k2, raw1, raw2;
    logic [1:0]  req, req_prev_q;
    logic [1:0]  af_fire;
    logic [1:0]  coin_q;
    logic [15:0] coin_cnt_q [2];
    coin_state_e coin_st_q  [2];
    logic        unused_bits;

    assign unused_bits = ^{joystick_0[15:9], joystick_1[15:9]};

    function automatic logic [7:0] joy_word(input logic [15:0] j);
        return {j[7], j[6], j[5], j[4], j[0], j[1], j[2], j[3]};
    endfunction

    // dir and result are {right, left, down, up}; opposite pairs cancel before rotation
    function automatic logic [3:0] steer(input logic [3:0] dir, input logic [1:0] rot);
        logic u, d, l, r;
        u = dir[0] & ~dir[1];
        d = dir[1] & ~dir[0];
        l = dir[2] & ~dir[3];
        r = dir[3] & ~dir[2];
        case (rot)
            2'd1:    return {u, d, r, l};
            2'd2:    return {l, r, u, d};
            2'd3:    return {d, u, l, r};
            default: return {r, l, d, u};
        endcase
    endfunction

    always_comb begin
        evt         = primed_q & (ps2_key[64] ^ tog_q);
        pressed     = ps2_key[15:8] != 8'hF0;
        ext         = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
        code        = (|ps2_key[63:24]) ? 9'h000 : {ext, ps2_key[7:0]};
        tog_d       = ps2_key[64];
        primed_d    = 1'b1;
        key_event_d = evt;
        kl_d        = kl_q;
        if (evt) begin
            case (code)
                9'h175: kl_d[0]  = pressed;
                9'h172: kl_d[1]  = pressed;
                9'h16B: kl_d[2]  = pressed;
                9'h174: kl_d[3]  = pressed;
                9'h014: kl_d[4]  = pressed;
                9'h029: kl_d[5]  = pressed;
                9'h011: kl_d[6]  = pressed;
                9'h005: kl_d[7]  = pressed;
                9'h02E: kl_d[8]  = pressed;
                9'h02D: kl_d[9]  = pressed;
                9'h02B: kl_d[10] = pressed;
                9'h023: kl_d[11] = pressed;
                9'h034: kl_d[12] = pressed;
                9'h01C: kl_d[13] = pressed;
                9'h01B: kl_d[14] = pressed;
                9'h006: kl_d[15] = pressed;
                9'h036: kl_d[16] = pressed;
                default: ;
            endcase
        end
    end

    always_comb begin
        k1 = {kl_q[8], kl_q[7], kl_q[6], kl_q[4] | kl_q[5], kl_q[3], kl_q[2], kl_q[1], kl_q[0]};
        k2 = kl_q[16:9];
        if (PLAYERS == 1) begin
            raw1 = k1 | k2 | joy_word(joystick_0) | joy_word(joystick_1);
            raw2 = 8'h00;
        end else begin
            raw1 = k1 | joy_word(joystick_0);
            raw2 = k2 | joy_word(joystick_1);
        end
        // Rotation only changes while every direction is released so a held stick never jumps
        rot_d   = (|{raw1[3:0], raw2[3:0]}) ? rot_q : rotate;
        ctrl1_d = {raw1[6:5], raw1[4] | af_fire[0], steer(raw1[3:0], rot_q)};
        ctrl2_d = {raw2[6:5], raw2[4] | af_fire[1], steer(raw2[3:0], rot_q)};
        req     = {raw2[7] | (COIN_FROM_START & raw2[6]), raw1[7] | (COIN_FROM_START & raw1[6])};
    end

`ifdef INPUT_AUTOFIRE_EN
    localparam int AF_W = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;
    logic [AF_W-1:0] af_cnt_q, af_cnt_d;
    logic            af_phase_q, af_phase_d;
    logic [1:0]      af_req;

    assign af_req  = (PLAYERS == 1) ? {1'b0, joystick_0[8] | joystick_1[8]}
                                    : {joystick_1[8], joystick_0[8]};
    assign af_fire = af_req & {2{af_phase_q}};

    always_comb begin
        af_cnt_d   = af_cnt_q + 1'b1;
        af_phase_d = af_phase_q;
        if (af_cnt_q == AF_W'(AF_DIV - 1)) begin
            af_cnt_d   = '0;
            af_phase_d = ~af_phase_q;
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b0;
        end else begin
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
        end
    end
`else
    logic unused_af;
    assign unused_af = ^{joystick_0[8], joystick_1[8], AF_DIV[0]};
    assign af_fire   = 2'b00;
`endif

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            tog_q       <= 1'b0;
            primed_q    <= 1'b0;
            key_event_q <= 1'b0;
            kl_q        <= '0;
            rot_q       <= 2'd0;
            ctrl1_q     <= '0;
            ctrl2_q     <= '0;
        end else begin
            tog_q       <= tog_d;
            primed_q    <= primed_d;
            key_event_q <= key_event_d;
            kl_q        <= kl_d;
            rot_q       <= rot_d;
            ctrl1_q     <= ctrl1_d;
            ctrl2_q     <= ctrl2_d;
        end
    end

    // Coin pulse: fixed-length, no retrigger, re-armed only after the request drops
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            req_prev_q <= 2'b00;
            coin_q     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                coin_st_q[i]  <= ST_IDLE;
                coin_cnt_q[i] <= 16'd0;
            end
        end else begin
            req_prev_q <= req;
            for (int i = 0; i < 2; i++) begin
                case (coin_st_q[i])
                    ST_IDLE: if (req[i] && !req_prev_q[i]) begin
                        coin_st_q[i]  <= ST_PULSE;
                        coin_cnt_q[i] <= COIN_PULSE - 16'd1;
                        coin_q[i]     <= 1'b1;
                    end
                    ST_PULSE: if (coin_cnt_q[i] == 16'd0) begin
                        coin_st_q[i] <= ST_WAIT;
                        coin_q[i]    <= 1'b0;
                    end else begin
                        coin_cnt_q[i] <= coin_cnt_q[i] - 16'd1;
                    end
                    ST_WAIT: if (!req[i]) coin_st_q[i] <= ST_IDLE;
                    default: begin
                        coin_st_q[i] <= ST_IDLE;
                        coin_q[i]    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign p1_ctrl   = {coin_q[0], ctrl1_q};
    assign p2_ctrl   = (PLAYERS == 1) ? 8'h00 : {coin_q[1], ctrl2_q};
    assign key_event = key_event_q;

endmodule
